la_capture: RTL and testbench

LA_CAPTURE -- requirements
Module: la_capture

---
 rtl/la_capture.sv | 220 ++++++++++++++++++++++
 tb/tb_la_capture.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/la_capture.sv
// Logic-analyser capture engine: multi-stage trigger, circular pre/post-trigger buffer, stalled readout.
// Optional per-sample 32-bit timestamps are built only when LA_TIMESTAMP_EN is defined.
//
// state | meaning
// IDLE  | waiting for arm_i; trace ignored
// PRE   | filling the pre-trigger window
// WAIT  | sampling, stepping through trigger stages
// POST  | filling the post-trigger window
// DONE  | capture complete, waiting for first rd_en_i
// READ  | streaming the buffer out
module la_capture #(
    parameter int TRACE_W    = 64,
    parameter int DEPTH_LOG2 = 10,
    parameter int STAGES     = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic [TRACE_W-1:0]          trace_i,
    input  logic [STAGES*TRACE_W-1:0]   trig_value_i,
    input  logic [STAGES*TRACE_W-1:0]   trig_mask_i,
    input  logic [DEPTH_LOG2-1:0]       pretrig_i,
    input  logic                        arm_i,
    input  logic                        abort_i,
    output logic [2:0]                  state_o,
    output logic                        triggered_o,
    output logic                        done_o,
    input  logic                        rd_en_i,
    output logic                        rd_valid_o,
    output logic                        rd_last_o,
    output logic [TRACE_W-1:0]          rd_data_o,
    output logic [31:0]                 rd_ts_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_MAX = '1;
    localparam logic [DEPTH_LOG2-1:0] CNT_ONE = DEPTH_LOG2'(1);
    localparam logic [1:0] LAST_STAGE = 2'(STAGES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4,
        S_READ = 3'd5
    } state_t;

    state_t state, state_nx;
    logic [DEPTH_LOG2-1:0] wptr, rptr, cnt, pre_len, trig_addr, rd_addr;
    logic [1:0]            stage_idx;
    logic [STAGES-1:0]     stage_hit;
    logic                  cur_hit, wr_en, rd_fire, rd_end, arm_ok;
    logic                  triggered, done, rd_valid, rd_last;
    logic [TRACE_W-1:0]    rd_data;
    logic [TRACE_W-1:0]    mem [DEPTH];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        assign stage_hit[k] = ((trace_i ^ trig_value_i[k*TRACE_W +: TRACE_W])
                               & trig_mask_i[k*TRACE_W +: TRACE_W]) == '0;
    end

    always_comb begin
        cur_hit = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            if (stage_idx == k[1:0]) cur_hit = stage_hit[k];
        end
    end

    always_comb begin
        state_nx = state;
        wr_en    = 1'b0;
        rd_fire  = 1'b0;
        rd_end   = 1'b0;
        rd_addr  = rptr;
        arm_ok   = 1'b0;
        case (state)
            S_IDLE: if (arm_i) begin
                arm_ok   = 1'b1;
                state_nx = S_PRE;
            end
            S_PRE: begin
                wr_en = 1'b1;
                if (cnt <= CNT_ONE) state_nx = S_WAIT;
            end
            S_WAIT: begin
                wr_en = 1'b1;
                if (cur_hit && stage_idx == LAST_STAGE)
                    state_nx = (pre_len == PTR_MAX) ? S_DONE : S_POST;
            end
            S_POST: begin
                wr_en = 1'b1;
                if (cnt == CNT_ONE) state_nx = S_DONE;
            end
            // The rd_en_i that leaves DONE already fetches the oldest sample.
            S_DONE: begin
                rd_addr = trig_addr - pre_len;
                if (rd_en_i) begin
                    rd_fire  = 1'b1;
                    state_nx = S_READ;
                end
            end
            S_READ: if (rd_en_i) begin
                rd_fire = 1'b1;
                if (cnt == CNT_ONE) begin
                    rd_end   = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        if (abort_i) begin
            state_nx = S_IDLE;
            wr_en    = 1'b0;
            rd_fire  = 1'b0;
            rd_end   = 1'b0;
            arm_ok   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state     <= S_IDLE;
            wptr      <= '0;
            rptr      <= '0;
            cnt       <= '0;
            pre_len   <= '0;
            trig_addr <= '0;
            stage_idx <= '0;
            triggered <= 1'b0;
            done      <= 1'b0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
        end else begin
            state    <= state_nx;
            rd_valid <= rd_fire;
            rd_last  <= rd_end;
            if (wr_en) wptr <= wptr + CNT_ONE;
            if (rd_fire) rptr <= rd_addr + CNT_ONE;
            if (abort_i) begin
                triggered <= 1'b0;
                done      <= 1'b0;
                stage_idx <= '0;
            end else begin
                case (state)
                    // pretrig_i cannot exceed DEPTH-1 at this width, so no clamp is needed.
                    S_IDLE: if (arm_ok) begin
                        wptr      <= '0;
                        cnt       <= pretrig_i;
                        pre_len   <= pretrig_i;
                        stage_idx <= '0;
                        triggered <= 1'b0;
                        done      <= 1'b0;
                    end
                    S_PRE: if (cnt > CNT_ONE) cnt <= cnt - CNT_ONE;
                    S_WAIT: if (cur_hit) begin
                        if (stage_idx == LAST_STAGE) begin
                            trig_addr <= wptr;
                            triggered <= 1'b1;
                            cnt       <= PTR_MAX - pre_len;
                            if (pre_len == PTR_MAX) done <= 1'b1;
                        end else begin
                            stage_idx <= stage_idx + 2'd1;
                        end
                    end
                    S_POST: begin
                        cnt <= cnt - CNT_ONE;
                        if (cnt == CNT_ONE) done <= 1'b1;
                    end
                    S_DONE: if (rd_en_i) cnt <= PTR_MAX;
                    S_READ: if (rd_en_i) begin
                        cnt <= cnt - CNT_ONE;
                        if (cnt == CNT_ONE) begin
                            done      <= 1'b0;
                            triggered <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wptr] <= trace_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i)     rd_data <= '0;
        else if (rd_fire) rd_data <= mem[rd_addr];
    end

`ifdef LA_TIMESTAMP_EN
    logic [31:0] ts_cnt, rd_ts;
    logic [31:0] ts_mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || arm_ok) ts_cnt <= '0;
        else                    ts_cnt <= ts_cnt + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) ts_mem[wptr] <= ts_cnt;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i)     rd_ts <= '0;
        else if (rd_fire) rd_ts <= ts_mem[rd_addr];
    end

    assign rd_ts_o = rd_ts;
`else
    assign rd_ts_o = '0;
`endif

    assign state_o     = state;
    assign triggered_o = triggered;
    assign done_o      = done;
    assign rd_valid_o  = rd_valid;
    assign rd_last_o   = rd_last;
    assign rd_data_o   = rd_data;
endmodule

// File: tb/tb_la_capture.sv
// Self-checking bench for la_capture (TRACE_W=16, DEPTH=16, STAGES=2); trace_i is a cycle counter.
// Expected captures are derived from the trigger rules applied to the known trace sequence.
module tb_la_capture;
    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [15:0] trace_i = '0;
    logic [31:0] trig_value_i = '0;
    logic [31:0] trig_mask_i = '0;
    logic [3:0]  pretrig_i = '0;
    logic        arm_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [2:0]  state_o;
    logic        triggered_o, done_o;
    logic        rd_en_i = 1'b0;
    logic        rd_valid_o, rd_last_o;
    logic [15:0] rd_data_o;
    logic [31:0] rd_ts_o;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    la_capture #(.TRACE_W(16), .DEPTH_LOG2(4), .STAGES(2)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .trace_i(trace_i),
        .trig_value_i(trig_value_i), .trig_mask_i(trig_mask_i),
        .pretrig_i(pretrig_i), .arm_i(arm_i), .abort_i(abort_i),
        .state_o(state_o), .triggered_o(triggered_o), .done_o(done_o),
        .rd_en_i(rd_en_i), .rd_valid_o(rd_valid_o), .rd_last_o(rd_last_o),
        .rd_data_o(rd_data_o), .rd_ts_o(rd_ts_o)
    );

    always #5 clk_i = ~clk_i;

    // The trace value sampled at the edge closing cycle c is c (mod 2^16).
    task automatic step();
        @(posedge clk_i);
        #1;
        cyc++;
        trace_i = 16'(cyc);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"}, 64'(state_o), 64'd0);
        chk({tag, "_trig"}, 64'(triggered_o), 64'd0);
        chk({tag, "_done"}, 64'(done_o), 64'd0);
        chk({tag, "_valid"}, 64'(rd_valid_o), 64'd0);
        chk({tag, "_last"}, 64'(rd_last_o), 64'd0);
        chk({tag, "_data"}, 64'(rd_data_o), 64'd0);
        chk({tag, "_ts"}, 64'(rd_ts_o), 64'd0);
    endtask

    // Predicted cycle of the trigger sample: stages are matched strictly in order, one per sample.
    function automatic int predict_trigger(input int wait_start, input logic [31:0] val,
                                           input logic [31:0] msk);
        int s = 0;
        for (int c = wait_start; c < wait_start + 5000; c++) begin
            logic [15:0] v;
            v = 16'(c);
            if (((v ^ val[s*16 +: 16]) & msk[s*16 +: 16]) == 16'h0) begin
                s++;
                if (s == 2) return c;
            end
        end
        return -1;
    endfunction

    // mode 0: rd_en every cycle, 1: alternating 1,0,..., 2: random
    task automatic readout(input int first, input int arm_cyc, input int mode);
        int k = 0;
        int guard = 0;
        bit en;
        while (k < 16 && guard < 200) begin
            case (mode)
                0:       en = 1'b1;
                1:       en = (guard % 2 == 0);
                default: en = 1'($urandom_range(0, 1));
            endcase
            rd_en_i = en;
            step();
            guard++;
            chk("rd_valid", 64'(rd_valid_o), 64'(en));
            if (en) begin
                chk("rd_data", 64'(rd_data_o), 64'(16'(first + k)));
                chk("rd_last", 64'(rd_last_o), 64'(k == 15));
`ifdef LA_TIMESTAMP_EN
                chk("rd_ts", 64'(rd_ts_o), 64'(32'(first + k - arm_cyc - 1)));
`else
                chk("rd_ts", 64'(rd_ts_o), 64'(32'(arm_cyc * 0)));
`endif
                k++;
            end
        end
        rd_en_i = 1'b0;
        chk("end_state", 64'(state_o), 64'd0);
        chk("end_done", 64'(done_o), 64'd0);
        chk("end_trig", 64'(triggered_o), 64'd0);
        rd_en_i = 1'b1;
        step();
        rd_en_i = 1'b0;
        chk("idle_rd_valid", 64'(rd_valid_o), 64'd0);
    endtask

    task automatic run_capture(input logic [31:0] val, input logic [31:0] msk, input int p,
                               input int mode, output int t_obs);
        int a, w, t, budget;
        trig_value_i = val;
        trig_mask_i  = msk;
        pretrig_i    = 4'(p);
        arm_i = 1'b1;
        a = cyc;
        step();
        arm_i = 1'b0;
        chk("arm_state", 64'(state_o), 64'd1);
        w = a + 1 + ((p == 0) ? 1 : p);
        t = predict_trigger(w, val, msk);
        budget = 0;
        while (!triggered_o && budget < 3000) begin
            step();
            budget++;
        end
        t_obs = cyc - 1;
        chk("trig_cycle", 64'(t_obs), 64'(t));
        chk("trig_state", 64'(state_o), (p == 15) ? 64'd4 : 64'd3);
        budget = 0;
        while (!done_o && budget < 100) begin
            step();
            budget++;
        end
        chk("done_cycle", 64'(cyc - 1), 64'(t + 15 - p));
        chk("done_state", 64'(state_o), 64'd4);
        readout(t - p, a, mode);
    endtask

    initial begin
        int t_obs;
        logic [31:0] rv, rm;

        rst_n_i = 1'b0;
        step();
        step();
        chk_reset_outputs("reset");
        rst_n_i = 1'b1;
        step();

        // Two-stage trigger on low-byte matches; pre-trigger window of 4.
        run_capture({16'h0032, 16'h007a}, {16'h00ff, 16'h00ff}, 4, 0, t_obs);
        chk("trig_value_0132", 64'(16'(t_obs)), 64'h0132);

        // All-care-nothing masks, no pre-trigger samples.
        run_capture(32'h0, 32'h0, 0, 0, t_obs);

        // Largest pre-trigger window: DONE straight after the trigger.
        run_capture({16'h0005, 16'h0003}, {16'h000f, 16'h000f}, 15, 2, t_obs);

        // Stalled readout, rd_en alternating.
        run_capture({16'h0001, 16'h0000}, {16'h0003, 16'h0003}, 7, 1, t_obs);

        // Abort wins over arm in IDLE.
        arm_i = 1'b1;
        abort_i = 1'b1;
        step();
        arm_i = 1'b0;
        abort_i = 1'b0;
        chk("abort_arm_state", 64'(state_o), 64'd0);

        // Abort during POST discards the capture.
        trig_value_i = '0;
        trig_mask_i = '0;
        pretrig_i = 4'd2;
        arm_i = 1'b1;
        step();
        arm_i = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("post_state", 64'(state_o), 64'd3);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk("abort_state", 64'(state_o), 64'd0);
        chk("abort_done", 64'(done_o), 64'd0);
        chk("abort_trig", 64'(triggered_o), 64'd0);
        rd_en_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_rd_valid", 64'(rd_valid_o), 64'd0);
        end
        rd_en_i = 1'b0;

        // Reset in WAIT; arm outside IDLE is ignored.
        trig_value_i = {16'h0, 16'(cyc + 2000)};
        trig_mask_i = 32'hffff_ffff;
        pretrig_i = 4'd3;
        arm_i = 1'b1;
        step();
        arm_i = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("wait_state", 64'(state_o), 64'd2);
        arm_i = 1'b1;
        step();
        arm_i = 1'b0;
        chk("rearm_ignored", 64'(state_o), 64'd2);
        rst_n_i = 1'b0;
        step();
        rst_n_i = 1'b1;
        chk_reset_outputs("midreset");
        run_capture({16'h0000, 16'h0002}, {16'h0001, 16'h0003}, 5, 0, t_obs);

        // Randomized captures.
        for (int n = 0; n < 8; n++) begin
            rv = $urandom;
            rm = {8'h0, 8'($urandom) & 8'($urandom), 8'h0, 8'($urandom) & 8'($urandom)};
            run_capture(rv, rm, int'($urandom_range(0, 15)), int'($urandom_range(0, 2)), t_obs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
